// File: rtl/fb_scanout_arbiter.sv
// Framebuffer port arbiter: shares one memory port between GPU writes and display
// scan-out reads, buffering scan pixels in a small FIFO that feeds the video block.
module fb_scanout_arbiter #(
   parameter int H_PIX = 720,
   parameter int V_PIX = 480,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_en,
   input  logic        gpu_req,
   input  logic [18:0] gpu_addr,
   input  logic [23:0] gpu_wdata,
   output logic        gpu_gnt,
   output logic [18:0] mem_addr,
   output logic        mem_we,
   output logic [23:0] mem_wdata,
   input  logic [23:0] mem_rdata,
   output logic [23:0] vid_data,
   output logic        vid_en,
   input  logic        vid_rdy,
   output logic        frame_start
);

   localparam int DATA_W = 24;
   localparam int ADDR_W = 19;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
   localparam logic [CNT_W:0]    FULL_OCC  = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W:0]    HALF_OCC  = (CNT_W + 1)'(DEPTH / 2);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                inflight_q, inflight_d;
   logic                vid_en_q, vid_en_d;
   logic [DATA_W-1:0]   vid_data_q, vid_data_d;
   logic                frame_start_q, frame_start_d;
   logic [DATA_W-1:0]   fifo_q [DEPTH];

   logic [CNT_W:0]      occ;
   logic                room;
   logic                urgent;
   logic                rd_issue;
   logic                wr_issue;
   logic                flush_entry;
   logic                push;
   logic                pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (scan_en) state_d = RUN;
         RUN:     if (!scan_en) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Occupancy counts the read still in flight so a returning word always has a slot.
   always_comb begin
      occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      room     = occ < FULL_OCC;
      urgent   = occ < HALF_OCC;
      rd_issue = 1'b0;
      wr_issue = 1'b0;
      if (!rst) begin
         case (state_q)
            RUN: begin
               if (urgent && room) begin
                  rd_issue = 1'b1;
               end else if (gpu_req) begin
                  wr_issue = 1'b1;
               end else if (room) begin
                  rd_issue = 1'b1;
               end
            end
            default: wr_issue = gpu_req;
         endcase
      end
      gpu_gnt   = wr_issue;
      mem_we    = wr_issue;
      mem_wdata = gpu_wdata;
      if (rst) begin
         mem_addr = '0;
      end else if (wr_issue) begin
         mem_addr = gpu_addr;
      end else begin
         mem_addr = scan_addr_q;
      end
   end

   // Leaving RUN drops buffered pixels and the pending return so the next frame starts clean.
   always_comb begin
      flush_entry   = (state_q == RUN) && !scan_en;
      push          = inflight_q;
      pop           = vid_rdy && (count_q != '0) && !vid_en_q && !flush_entry;
      scan_addr_d   = scan_addr_q;
      if (rd_issue) begin
         scan_addr_d = (scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + 1'b1;
      end
      inflight_d    = rd_issue;
      frame_start_d = rd_issue && (scan_addr_q == '0);
      vid_en_d      = pop;
      vid_data_d    = pop ? fifo_q[rd_ptr_q] : vid_data_q;
      wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d       = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (flush_entry) begin
         scan_addr_d = '0;
         inflight_d  = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_addr_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         vid_en_q      <= 1'b0;
         vid_data_q    <= '0;
         frame_start_q <= 1'b0;
      end else begin
         scan_addr_q   <= scan_addr_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         vid_en_q      <= vid_en_d;
         vid_data_q    <= vid_data_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush_entry) begin
         fifo_q[wr_ptr_q] <= mem_rdata;
      end
   end

   assign vid_en      = vid_en_q;
   assign vid_data    = vid_data_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/fb_scanout_arbiter.md
FB_SCANOUT_ARBITER -- requirements
Module: fb_scanout_arbiter

Interface
REQ-001 The block SHALL have parameter H_PIX, default 720, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_PIX, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning pixel FIFO entries (power of two, >=4).
REQ-004 The block SHALL have port clk  in  1  system clock, all logic on posedge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port scan_en  in  1  level; 1 = display scan-out running.
REQ-007 The block SHALL have port gpu_req  in  1  GPU write request, held until granted.
REQ-008 The block SHALL have port gpu_addr  in  19  GPU framebuffer word address.
REQ-009 The block SHALL have port gpu_wdata  in  24  GPU RGB888 write data.
REQ-010 The block SHALL have port gpu_gnt  out  1  combinational; 1 = GPU write issued this cycle.
REQ-011 The block SHALL have port mem_addr  out  19  framebuffer address, combinational.
REQ-012 The block SHALL have port mem_we  out  1  framebuffer write strobe, combinational.
REQ-013 The block SHALL have port mem_wdata  out  24  framebuffer write data (= gpu_wdata).
REQ-014 The block SHALL have port mem_rdata  in  24  read data, valid exactly 1 cycle after a read issue.
REQ-015 The block SHALL have port vid_data  out  24  registered pixel to video output block.
REQ-016 The block SHALL have port vid_en  out  1  registered one-cycle pixel strobe.
REQ-017 The block SHALL have port vid_rdy  in  1  video block ready for next pixel.
REQ-018 The block SHALL have port frame_start  out  1  registered pulse, read of address 0 issued.

Function
REQ-019 States SHALL be IDLE, RUN, FLUSH; IDLE->RUN when scan_en=1; RUN->FLUSH when scan_en=0; FLUSH->IDLE after exactly one cycle.
REQ-020 Per cycle exactly one memory op: GPU write, scan read, or none; a read is issued when mem_we=0 and rd_issue=1.
REQ-021 Room SHALL be defined as fifo_count + inflight < DEPTH; urgent as fifo_count + inflight < DEPTH/2.
REQ-022 In RUN: urgent and room -> scan read; else gpu_req -> GPU write (gpu_gnt=1, mem_we=1, mem_addr=gpu_addr); else room -> scan read; else idle.
REQ-023 In IDLE and FLUSH, gpu_req SHALL be granted in the same cycle with no scan reads issued.
REQ-024 Scan address SHALL increment by 1 per scan read, wrapping from H_PIX*V_PIX-1 to 0; no multiplier.
REQ-025 frame_start SHALL pulse for 1 cycle, the cycle after a scan read of address 0 issues.
REQ-026 Read data SHALL be pushed into the FIFO the cycle after issue; inflight is 0 or 1.
REQ-027 vid_en SHALL assert for one cycle when vid_rdy=1, FIFO non-empty, vid_en=0 last cycle; vid_data loads the FIFO head that edge; FIFO pops.
REQ-028 vid_en SHALL never assert on consecutive cycles; vid_data SHALL hold between strobes.
REQ-029 Simultaneous push and pop SHALL leave fifo_count unchanged; push when full SHALL never occur (guaranteed by REQ-021).
REQ-030 Entering FLUSH SHALL empty the FIFO, reset scan address to 0, discard any in-flight read return, and suppress vid_en.

Reset
REQ-031 During rst: state IDLE, scan address 0, FIFO empty, inflight 0, vid_en 0, vid_data 0, frame_start 0.
REQ-032 During rst: gpu_gnt 0, mem_we 0, mem_addr 0; asserting rst mid-frame SHALL abort all state the same cycle.

Verification
REQ-033 Reset, scan_en=1, vid_rdy=1, no GPU -> first read addr 0, frame_start pulses next cycle, FIFO fills to 8, vid_en period >=2 cycles, data in address order.
REQ-034 FIFO count 6, gpu_req held -> GPU granted every cycle until count+inflight <4, then one scan read, gpu_gnt=0 that cycle.
REQ-035 H_PIX=4, V_PIX=2 -> reads addr 0..7 then 0; frame_start pulses twice, 8 reads apart.
REQ-036 scan_en dropped with read in flight -> FLUSH 1 cycle, returned word discarded, FIFO empty, vid_en low, restart at addr 0.
REQ-037 vid_rdy held 0 -> FIFO fills to DEPTH, no further reads, GPU granted every cycle, no overflow.
REQ-038 rst asserted mid-frame with gpu_req=1 -> gpu_gnt, mem_we, vid_en drop immediately; after release, IDLE.
